// File: rtl/gb_apu_wave_ram_arbiter_if.sv
// Wave RAM access bundle: CPU req/ack port plus the channel 3 fetch port.
// Latency: none (wires only).
// Backpressure: CPU holds cpu_req until cpu_ack; channel fetches are never refused.
//
// Signals (master = requesters, slave = wave RAM arbiter):
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  -> CPU access request, held until cpu_ack
//   cpu_ack/cpu_rdata                  <- completion pulse and read data
//   ch_on/ch_fetch/ch_addr             -> channel 3 enable and fetch pulse
//   ch_data/ch_valid                   <- fetched byte and its one-cycle strobe
interface gb_apu_wave_ram_arbiter_if #(
    parameter int AW = 4
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          cpu_ack;
    logic [7:0]    cpu_rdata;
    logic          ch_on;
    logic          ch_fetch;
    logic [AW-1:0] ch_addr;
    logic [7:0]    ch_data;
    logic          ch_valid;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output ch_on, ch_fetch, ch_addr,
        input  ch_data, ch_valid
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  ch_on, ch_fetch, ch_addr,
        output ch_data, ch_valid
    );
endinterface

// File: rtl/gb_apu_wave_ram_arbiter.sv
// Channel 3 wave RAM owner, arbitrating one RAM port between CPU and channel fetches.
// Latency: fetch 1 cycle (2 if it loses to a forced CPU grant); CPU 1 cycle (2 if contended).
// Backpressure: channel always wins except vs. a forced CPU grant; CPU waits at most 1 cycle.
//
// Ports:
//   clk      APU system clock
//   reset_n  asynchronous active-low reset; aborts any CPU access in flight (no ack)
//   bus      gb_apu_wave_ram_arbiter_if.slave: CPU req/ack port and channel fetch port
// Parameters:
//   DEPTH      wave RAM size in bytes (address width $clog2(DEPTH))
//   INIT_BYTE  value every RAM byte takes on reset
// Build option:
//   GB_APU_WAVE_DMG_QUIRK_EN  while ch_on=1, CPU accesses are redirected to the byte the
//                             channel last fetched, and only succeed in the cycle right
//                             after a fetch (otherwise reads return 8'hFF, writes drop).
module gb_apu_wave_ram_arbiter #(
    parameter int         DEPTH     = 16,
    parameter logic [7:0] INIT_BYTE = 8'h00
) (
    input  logic                       clk,
    input  logic                       reset_n,
    gb_apu_wave_ram_arbiter_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    // IDLE   : ready for a CPU request.
    // WAIT   : CPU lost this edge to a fetch; it is granted unconditionally at the next edge.
    // ACCESS : the CPU access has executed; cpu_ack is high and cpu_req from the finished
    //          request is ignored for this cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [7:0]    mem [DEPTH];

    logic          fetch_pend;
    logic [AW-1:0] pend_addr;

    logic          cpu_ack;
    logic [7:0]    cpu_rdata;
    logic [7:0]    ch_data;
    logic          ch_valid;

    // Arbitration decode for the coming edge.
    logic          forced;
    logic          fetch_req;
    logic          fetch_go;
    logic [AW-1:0] fetch_addr;
    logic          cpu_go;
    logic [AW-1:0] cpu_addr_eff;
    logic          cpu_allow;

`ifdef GB_APU_WAVE_DMG_QUIRK_EN
    logic [AW-1:0] last_addr;
    logic          recent;
`endif

    always_comb begin
        forced     = (state == WAIT);
        // A fetch wanting the port: a new pulse or one held over from a lost edge.
        fetch_req  = bus.ch_on & (bus.ch_fetch | fetch_pend);
        // A fresh pulse overrides the held-over address; only one fetch is issued.
        fetch_addr = bus.ch_fetch ? bus.ch_addr : pend_addr;
        fetch_go   = fetch_req & ~forced;
        cpu_go     = forced | ((state == IDLE) & bus.cpu_req & ~fetch_req);
    end

    always_comb begin
        cpu_addr_eff = bus.cpu_addr;
        cpu_allow    = 1'b1;
`ifdef GB_APU_WAVE_DMG_QUIRK_EN
        if (bus.ch_on) begin
            cpu_addr_eff = last_addr;
            cpu_allow    = recent;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.cpu_req) begin
                    state_nxt = fetch_req ? WAIT : ACCESS;
                end
            end
            WAIT:    state_nxt = ACCESS;
            ACCESS:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Single RAM port: fetch_go and cpu_go are mutually exclusive by construction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT_BYTE;
            end
        end else if (cpu_go && bus.cpu_we && cpu_allow) begin
            mem[cpu_addr_eff] <= bus.cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_ack   <= 1'b0;
            cpu_rdata <= 8'h00;
        end else begin
            cpu_ack <= cpu_go;
            if (cpu_go && !bus.cpu_we) begin
                cpu_rdata <= cpu_allow ? mem[cpu_addr_eff] : 8'hFF;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_data    <= 8'h00;
            ch_valid   <= 1'b0;
            fetch_pend <= 1'b0;
            pend_addr  <= '0;
        end else begin
            ch_valid <= fetch_go;
            if (fetch_go) begin
                ch_data <= mem[fetch_addr];
            end
            // Held only when a wanted fetch collides with a forced grant; dropping
            // ch_on or executing the fetch clears it.
            fetch_pend <= fetch_req & forced;
            if (fetch_req && forced) begin
                pend_addr <= fetch_addr;
            end
        end
    end

`ifdef GB_APU_WAVE_DMG_QUIRK_EN
    // recent marks the single cycle after a fetch, the only window in which the
    // CPU can reach the RAM while the channel plays.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_addr <= '0;
            recent    <= 1'b0;
        end else begin
            recent <= fetch_go;
            if (fetch_go) begin
                last_addr <= fetch_addr;
            end
        end
    end
`endif

    assign bus.cpu_ack   = cpu_ack;
    assign bus.cpu_rdata = cpu_rdata;
    assign bus.ch_data   = ch_data;
    assign bus.ch_valid  = ch_valid;

endmodule
